// File: rtl/coco_irq_pkg.sv
// Shared definitions for the coco interrupt controller: FSM states,
// register map and CTRL bit positions.
package coco_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_VEC  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_EDGE = 1;

endpackage

// File: rtl/coco_prio_enc.sv
// Lowest-index-wins priority encoder: index of the lowest set request bit
// plus a valid flag. Index is 0 when nothing is requesting.
module coco_prio_enc #(
    parameter int N_SRC = 6,
    parameter int VEC_W = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic [VEC_W-1:0] idx,
    output logic             valid
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = VEC_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/coco_irq_ctrl.sv
// Interrupt controller: captures and masks peripheral lines, arbitrates by
// fixed priority and runs a claim / EOI handshake with software.
module coco_irq_ctrl
    import coco_irq_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int VEC_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:2]       add_i,
    input  logic             we_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    input  logic [N_SRC-1:0] src_i,
    output logic             irq_o,
    output logic [VEC_W-1:0] vec_o
);

    logic             en;
    logic             edge_mode;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] src_q;
    logic             isv;
    irq_state_e       state;

    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] set;
    logic [N_SRC-1:0] clr;
    logic [VEC_W-1:0] top;
    logic             act_valid;
    logic             any;
    logic             wr_ctrl, wr_mask, wr_pend, wr_vec;
    logic             claim;
    logic             unused_dat;

    assign wr_ctrl = we_i && (add_i == ADDR_CTRL);
    assign wr_mask = we_i && (add_i == ADDR_MASK);
    assign wr_pend = we_i && (add_i == ADDR_PEND);
    assign wr_vec  = we_i && (add_i == ADDR_VEC);

    assign act = pend & mask;
    assign any = en & act_valid;

    coco_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio (
        .req   (act),
        .idx   (top),
        .valid (act_valid)
    );

    // A claim is only honoured while the request is still live.
    assign claim = (state == IRQ_ASSERT) && wr_vec && any;
    assign set   = edge_mode ? (src_i & ~src_q) : src_i;
    assign clr   = (wr_pend ? dat_i[N_SRC-1:0] : '0)
                 | (claim ? (N_SRC'(1) << top) : '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en        <= 1'b0;
            edge_mode <= 1'b0;
            mask      <= '0;
            pend      <= '0;
            src_q     <= '0;
        end else begin
            src_q <= src_i;
            pend  <= (pend & ~clr) | set;
            if (wr_ctrl) begin
                en        <= dat_i[CTRL_EN];
                edge_mode <= dat_i[CTRL_EDGE];
            end
            if (wr_mask) mask <= dat_i[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IRQ_IDLE;
            irq_o <= 1'b0;
            vec_o <= '0;
            isv   <= 1'b0;
        end else begin
            unique case (state)
                IRQ_IDLE: begin
                    if (any) begin
                        state <= IRQ_ASSERT;
                        irq_o <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (!any) begin
                        state <= IRQ_IDLE;
                        irq_o <= 1'b0;
                    end else if (wr_vec) begin
                        state <= IRQ_SERVICE;
                        irq_o <= 1'b0;
                        vec_o <= top;
                        isv   <= 1'b1;
                    end
                end
                IRQ_SERVICE: begin
                    irq_o <= 1'b0;
                    if (wr_vec) begin
                        state <= IRQ_IDLE;
                        isv   <= 1'b0;
                    end
                end
                default: begin
                    state <= IRQ_IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dat_o = '0;
        unique case (add_i)
            ADDR_CTRL: begin
                dat_o[CTRL_EN]   = en;
                dat_o[CTRL_EDGE] = edge_mode;
            end
            ADDR_MASK: dat_o[N_SRC-1:0] = mask;
            ADDR_PEND: dat_o[N_SRC-1:0] = pend;
            ADDR_VEC: begin
                dat_o[31]        = isv;
                dat_o[VEC_W-1:0] = (state == IRQ_SERVICE) ? vec_o : top;
            end
            default: dat_o = '0;
        endcase
    end

    // Write-data bits above the register widths have no home.
    assign unused_dat = &{1'b0, dat_i};

endmodule

// File: tb/tb_coco_irq_ctrl.sv
// Scoreboard bench for coco_irq_ctrl: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_coco_irq_ctrl;

    localparam int N_SRC = 6;
    localparam int VEC_W = 4;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_VEC  = 2'd3;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [3:2]       add_i;
    logic             we_i;
    logic [31:0]      dat_i;
    logic [31:0]      dat_o;
    logic [N_SRC-1:0] src_i;
    logic             irq_o;
    logic [VEC_W-1:0] vec_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    coco_irq_ctrl #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .add_i   (add_i),
        .we_i    (we_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .src_i   (src_i),
        .irq_o   (irq_o),
        .vec_o   (vec_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic observe(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        add_i = a;
        dat_i = d;
        we_i  = 1'b1;
        tick();
        we_i  = 1'b0;
        dat_i = '0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] val);
        expect_val(tag, val);
        add_i = a;
        #1;
        observe(dat_o);
    endtask

    task automatic out_chk(input string tag, input logic [31:0] val_irq, input logic [31:0] val_vec);
        expect_val({tag, "_irq"}, val_irq);
        expect_val({tag, "_vec"}, val_vec);
        observe(32'(irq_o));
        observe(32'(vec_o));
    endtask

    task automatic pulse(input logic [N_SRC-1:0] s);
        src_i = s;
        tick();
        src_i = '0;
    endtask

    initial begin
        rst_n_i = 1'b0;
        add_i   = '0;
        we_i    = 1'b0;
        dat_i   = '0;
        src_i   = '0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();

        // Reset state
        rd_chk(A_CTRL, "rst_ctrl", 32'h0);
        rd_chk(A_MASK, "rst_mask", 32'h0);
        rd_chk(A_PEND, "rst_pend", 32'h0);
        rd_chk(A_VEC,  "rst_vec",  32'h0);
        out_chk("rst", 0, 0);

        // Edge capture, single source, claim and EOI
        wr(A_CTRL, 32'h3);
        wr(A_MASK, 32'h3F);
        pulse(6'h04);
        rd_chk(A_PEND, "edge_pend", 32'h04);
        out_chk("edge_pre", 0, 0);
        tick();
        out_chk("edge_irq", 1, 0);
        rd_chk(A_VEC, "assert_top", 32'h2);
        wr(A_VEC, 32'h0);
        out_chk("claim2", 0, 2);
        rd_chk(A_PEND, "claim2_pend", 32'h0);
        rd_chk(A_VEC,  "claim2_vec",  32'h8000_0002);
        wr(A_VEC, 32'h0);
        rd_chk(A_VEC, "eoi2_vec", 32'h0);
        out_chk("eoi2", 0, 2);

        // Two sources together: priority, EOI latency, second claim
        pulse(6'h12);
        tick();
        out_chk("two_irq", 1, 2);
        rd_chk(A_VEC, "two_top", 32'h1);
        wr(A_VEC, 32'h0);
        out_chk("claim1", 0, 1);
        rd_chk(A_PEND, "claim1_pend", 32'h10);
        wr(A_VEC, 32'h0);
        out_chk("eoi1_t", 0, 1);
        tick();
        out_chk("eoi1_t2", 1, 1);
        rd_chk(A_VEC, "next_top", 32'h4);
        wr(A_VEC, 32'h0);
        out_chk("claim4", 0, 4);
        rd_chk(A_PEND, "claim4_pend", 32'h0);
        wr(A_VEC, 32'h0);

        // Level mode: set wins over write-1-to-clear
        wr(A_CTRL, 32'h1);
        src_i = 6'h08;
        tick();
        wr(A_PEND, 32'h08);
        rd_chk(A_PEND, "lvl_setwins", 32'h08);
        src_i = '0;
        wr(A_PEND, 32'h08);
        rd_chk(A_PEND, "lvl_clr", 32'h0);
        tick();
        tick();
        out_chk("lvl_idle", 0, 4);
        wr(A_MASK, 32'hFFFF_FFFF);
        rd_chk(A_MASK, "mask_upper", 32'h3F);
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd_chk(A_CTRL, "ctrl_upper", 32'h3);

        // Masking drops the request; VEC write in IDLE is ignored
        pulse(6'h01);
        tick();
        out_chk("m_assert", 1, 4);
        wr(A_MASK, 32'h0);
        tick();
        out_chk("m_drop", 0, 4);
        wr(A_VEC, 32'h0);
        rd_chk(A_VEC,  "idle_vecwr", 32'h0);
        rd_chk(A_PEND, "idle_pend",  32'h01);
        out_chk("idle_vecwr", 0, 4);

        // SERVICE ignores new sources and EN drop; async reset mid-cycle
        wr(A_PEND, 32'h01);
        pulse(6'h20);
        wr(A_MASK, 32'h3F);
        tick();
        out_chk("s_assert", 1, 4);
        wr(A_VEC, 32'h0);
        out_chk("claim5", 0, 5);
        pulse(6'h01);
        wr(A_CTRL, 32'h0);
        tick();
        out_chk("svc_hold", 0, 5);
        rd_chk(A_PEND, "svc_pend", 32'h01);
        rd_chk(A_VEC,  "svc_vec",  32'h8000_0005);
        #2;
        rst_n_i = 1'b0;
        #1;
        out_chk("async_rst", 0, 0);
        rd_chk(A_PEND, "async_pend", 32'h0);
        rd_chk(A_VEC,  "async_vec",  32'h0);
        tick();
        rst_n_i = 1'b1;
        tick();

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
